// File: rtl/axi_arb_pkg.sv
// rtl/axi_arb_pkg.sv - shared state and direction types for the read/write memory arbiter
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        WRESP = 2'd2,
        READ  = 2'd3
    } arb_state_e;

    typedef enum logic {
        DIR_W = 1'b0,
        DIR_R = 1'b1
    } dir_e;

endpackage

// File: rtl/burst_beat_counter.sv
// rtl/burst_beat_counter.sv - burst length latch and beat offset counter shared by both directions
module burst_beat_counter #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_len,
    input  logic             inc,
    output logic [LEN_W-1:0] cnt,
    output logic             last
);

    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == len_q);
    assign cnt  = cnt_q;

    // The last beat does not advance, so a full 2^LEN_W burst ends at the top value without wrapping.
    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        if (load) begin
            len_d = load_len;
            cnt_d = '0;
        end else if (inc && !last) begin
            cnt_d = cnt_q + LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= '0;
            cnt_q <= '0;
        end else begin
            len_q <= len_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axi_rw_arbiter.sv
// rtl/axi_rw_arbiter.sv - round-robin single-port memory arbiter between AXI write and read bursts
module axi_rw_arbiter
    import axi_arb_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_req,
    input  logic             r_req,
    input  logic [LEN_W-1:0] aw_len,
    input  logic [LEN_W-1:0] ar_len,
    input  logic             w_empty,
    input  logic             r_full,
    input  logic             b_full,
    input  logic             mem_gnt,
    output logic             w_grant,
    output logic             r_grant,
    output logic             mem_req,
    output logic             mem_we,
    output logic [LEN_W-1:0] beat_idx,
    output logic             w_pop,
    output logic             aw_pop,
    output logic             ar_pop,
    output logic             r_push,
    output logic             b_push,
    output logic             busy
);

    arb_state_e state_q, state_d;
    dir_e       last_dir_q, last_dir_d;

    logic             cnt_load;
    logic [LEN_W-1:0] cnt_len;
    logic             beat;
    logic             last;
    logic             pick_w, pick_r;
    logic             mem_req_c, mem_we_c, w_pop_c, aw_pop_c, ar_pop_c, r_push_c, b_push_c;

    burst_beat_counter #(.LEN_W(LEN_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_len (cnt_len),
        .inc      (beat),
        .cnt      (beat_idx),
        .last     (last)
    );

    // On a tie the direction that did not finish last wins.
    assign pick_w = w_req && (!r_req || last_dir_q == DIR_R);
    assign pick_r = r_req && (!w_req || last_dir_q == DIR_W);

    always_comb begin
        state_d    = state_q;
        last_dir_d = last_dir_q;
        cnt_load   = 1'b0;
        cnt_len    = '0;
        beat       = 1'b0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        w_pop_c    = 1'b0;
        aw_pop_c   = 1'b0;
        ar_pop_c   = 1'b0;
        r_push_c   = 1'b0;
        b_push_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_w) begin
                    state_d  = WRITE;
                    cnt_load = 1'b1;
                    cnt_len  = aw_len;
                end else if (pick_r) begin
                    state_d  = READ;
                    cnt_load = 1'b1;
                    cnt_len  = ar_len;
                end
            end
            WRITE: begin
                mem_req_c = !w_empty;
                mem_we_c  = 1'b1;
                beat      = mem_req_c && mem_gnt;
                w_pop_c   = beat;
                aw_pop_c  = beat && last;
                if (beat && last) state_d = WRESP;
            end
            WRESP: begin
                b_push_c = !b_full;
                if (b_push_c) begin
                    state_d    = IDLE;
                    last_dir_d = DIR_W;
                end
            end
            READ: begin
                mem_req_c = !r_full;
                beat      = mem_req_c && mem_gnt;
                r_push_c  = beat;
                ar_pop_c  = beat && last;
                if (beat && last) begin
                    state_d    = IDLE;
                    last_dir_d = DIR_R;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are suppressed while reset is asserted so an aborted burst never touches a FIFO.
    assign mem_req = mem_req_c && !rst;
    assign mem_we  = mem_we_c  && !rst;
    assign w_pop   = w_pop_c   && !rst;
    assign aw_pop  = aw_pop_c  && !rst;
    assign ar_pop  = ar_pop_c  && !rst;
    assign r_push  = r_push_c  && !rst;
    assign b_push  = b_push_c  && !rst;

    assign w_grant = (state_q == WRITE) || (state_q == WRESP);
    assign r_grant = (state_q == READ);
    assign busy    = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_dir_q <= DIR_R;
        end else begin
            state_q    <= state_d;
            last_dir_q <= last_dir_d;
        end
    end

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// tb/tb_axi_rw_arbiter.sv - directed self-checking bench for axi_rw_arbiter
module tb_axi_rw_arbiter;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             w_req, r_req;
    logic [LEN_W-1:0] aw_len, ar_len;
    logic             w_empty, r_full, b_full, mem_gnt;
    logic             w_grant, r_grant, mem_req, mem_we;
    logic [LEN_W-1:0] beat_idx;
    logic             w_pop, aw_pop, ar_pop, r_push, b_push, busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    axi_rw_arbiter #(.LEN_W(LEN_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .w_req    (w_req),
        .r_req    (r_req),
        .aw_len   (aw_len),
        .ar_len   (ar_len),
        .w_empty  (w_empty),
        .r_full   (r_full),
        .b_full   (b_full),
        .mem_gnt  (mem_gnt),
        .w_grant  (w_grant),
        .r_grant  (r_grant),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .beat_idx (beat_idx),
        .w_pop    (w_pop),
        .aw_pop   (aw_pop),
        .ar_pop   (ar_pop),
        .r_push   (r_push),
        .b_push   (b_push),
        .busy     (busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outs"}, 32'({w_grant, r_grant, mem_req, mem_we, w_pop, aw_pop,
                                 ar_pop, r_push, b_push, busy}), 0);
        chk({tag, " beat_idx"}, 32'(beat_idx), 0);
    endtask

    initial begin
        int exp_w[10];
        int exp_r[10];
        int pushes, apops, bad_apop, wraps, cyc;
        logic [LEN_W-1:0] prev_idx;

        rst = 1'b1; w_req = 0; r_req = 0; aw_len = '0; ar_len = '0;
        w_empty = 0; r_full = 0; b_full = 0; mem_gnt = 1;
        tick(); tick();
        rst = 1'b0;
        settle();
        chk_all_zero("reset");

        // Write only, len 3: four pops, aw_pop on the fourth, b_push next, IDLE after 6 cycles.
        w_req = 1; aw_len = 8'd3;
        settle();
        chk("t1 no grant yet", 32'(w_grant), 0);
        tick();
        w_req = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("t1 w_grant", 32'(w_grant), 1);
            chk("t1 w_pop", 32'(w_pop), 1);
            chk("t1 mem_we", 32'(mem_we), 1);
            chk("t1 beat_idx", 32'(beat_idx), k);
            chk("t1 aw_pop", 32'(aw_pop), (k == 3) ? 1 : 0);
            tick();
        end
        settle();
        chk("t1 wresp b_push", 32'(b_push), 1);
        chk("t1 wresp w_pop", 32'(w_pop), 0);
        chk("t1 wresp grant", 32'(w_grant), 1);
        tick();
        settle();
        chk("t1 idle busy", 32'(busy), 0);

        // Both requests from reset, zero lengths: W W(resp) I R I W W I R I.
        rst = 1; tick(); rst = 0;
        w_req = 1; r_req = 1; aw_len = 0; ar_len = 0;
        exp_w = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
        exp_r = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        for (int i = 0; i < 10; i++) begin
            tick();
            settle();
            chk($sformatf("t2 w_grant[%0d]", i), 32'(w_grant), exp_w[i]);
            chk($sformatf("t2 r_grant[%0d]", i), 32'(r_grant), exp_r[i]);
            chk("t2 exclusive", 32'(w_grant && r_grant), 0);
        end
        w_req = 0; r_req = 0;
        tick();

        // Write len 2 with a 3-cycle W-empty stall after beat 0, then a 2-cycle B-full stall.
        w_req = 1; aw_len = 8'd2;
        tick();
        w_req = 0;
        settle();
        chk("t3 beat0 pop", 32'(w_pop), 1);
        chk("t3 beat0 idx", 32'(beat_idx), 0);
        for (int s = 0; s < 3; s++) begin
            tick();
            w_empty = 1;
            settle();
            chk("t3 stall pop", 32'(w_pop), 0);
            chk("t3 stall mem_req", 32'(mem_req), 0);
            chk("t3 stall idx", 32'(beat_idx), 1);
        end
        tick();
        w_empty = 0;
        settle();
        chk("t3 beat1 pop", 32'(w_pop), 1);
        chk("t3 beat1 idx", 32'(beat_idx), 1);
        tick();
        settle();
        chk("t3 beat2 idx", 32'(beat_idx), 2);
        chk("t3 beat2 aw_pop", 32'(aw_pop), 1);
        for (int s = 0; s < 2; s++) begin
            tick();
            b_full = 1;
            settle();
            chk("t3 bstall b_push", 32'(b_push), 0);
            chk("t3 bstall busy", 32'(busy), 1);
        end
        tick();
        b_full = 0;
        settle();
        chk("t3 b_push", 32'(b_push), 1);
        tick();
        settle();
        chk("t3 idle", 32'(busy), 0);
        chk("t3 no extra b_push", 32'(b_push), 0);

        // Read len 255 with R-full toggling every cycle.
        r_req = 1; ar_len = 8'd255;
        tick();
        r_req = 0;
        pushes = 0; apops = 0; bad_apop = 0; wraps = 0; cyc = 0;
        prev_idx = '0;
        while (busy && cyc < 2000) begin
            r_full = cyc[0];
            settle();
            if (r_push != !r_full) begin
                chk("t4 r_push vs r_full", 32'(r_push), 32'(!r_full));
            end
            if (r_push) pushes++;
            if (ar_pop) begin
                apops++;
                if (beat_idx != 8'd255) bad_apop++;
            end
            if (beat_idx < prev_idx) wraps++;
            prev_idx = beat_idx;
            cyc++;
            tick();
        end
        r_full = 0;
        settle();
        chk("t4 finished in budget", 32'(busy), 0);
        chk("t4 r_push count", pushes, 256);
        chk("t4 ar_pop count", apops, 1);
        chk("t4 ar_pop off last", bad_apop, 0);
        chk("t4 idx wraps", wraps, 0);
        chk("t4 final idx", 32'(beat_idx), 255);

        // Reset at beat 2 of a 4-beat write, then a tie must grant write.
        w_req = 1; aw_len = 8'd3;
        tick();
        w_req = 0;
        tick();
        tick();
        rst = 1;
        settle();
        chk("t5 idx at reset", 32'(beat_idx), 2);
        chk("t5 no pop in reset", 32'(w_pop), 0);
        chk("t5 no aw_pop in reset", 32'(aw_pop), 0);
        tick();
        rst = 0;
        settle();
        chk_all_zero("t5 after reset");
        w_req = 1; r_req = 1; aw_len = 0; ar_len = 0;
        tick();
        w_req = 0; r_req = 0;
        settle();
        chk("t5 tie w_grant", 32'(w_grant), 1);
        chk("t5 tie r_grant", 32'(r_grant), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_rw_arbiter.md
# axi_rw_arbiter

Arbitrates a single-port memory between the AXI write path and the AXI read path of the slave. Takes the channel-ready requests `w_req` and `r_req`, grants one direction round-robin, and holds the grant for the whole burst. Counts beats, issues FIFO pops and pushes, and completes the write response before releasing the memory. Sits between the channel FIFOs and the memory port; `w_grant` feeds back to the write-request logic.

## Interface
Parameters:
- `LEN_W`, 8: width of the AXI burst length field (beats = len + 1).

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `w_req`  in  1  write burst ready (AW and W not empty, B not full)
- `r_req`  in  1  read burst ready (AR not empty)
- `aw_len`  in  LEN_W  AW FIFO head length; sampled at grant
- `ar_len`  in  LEN_W  AR FIFO head length; sampled at grant
- `w_empty`  in  1  W data FIFO empty
- `r_full`  in  1  R data FIFO full
- `b_full`  in  1  B response FIFO full
- `mem_gnt`  in  1  memory accepts the current beat this cycle; read data is valid the same cycle
- `w_grant`  out  1  write direction owns the memory
- `r_grant`  out  1  read direction owns the memory
- `mem_req`  out  1  beat request to memory
- `mem_we`  out  1  1 = write beat
- `beat_idx`  out  LEN_W  beat offset within the burst, for address generation
- `w_pop`, `aw_pop`, `ar_pop`  out  1  FIFO pops
- `r_push`, `b_push`  out  1  FIFO pushes
- `busy`  out  1  state not IDLE

## Operation
- States: IDLE, WRITE, WRESP, READ.
- IDLE:
  - Only `w_req` high -> WRITE.
  - Only `r_req` high -> READ.
  - Both high -> the direction not equal to `last_dir` wins.
  - Entering a burst latches `len_q` from `aw_len` or `ar_len` and clears `beat_idx`.
- WRITE:
  - `mem_req = ~w_empty`, `mem_we = 1`.
  - A beat completes when `mem_req & mem_gnt`; it asserts `w_pop` and increments `beat_idx`.
  - The beat with `beat_idx == len_q` is the last: it also asserts `aw_pop`, and the state goes to WRESP.
- WRESP:
  - `b_push = ~b_full`.
  - On `b_push` -> IDLE, `last_dir = WRITE`.
- READ:
  - `mem_req = ~r_full`, `mem_we = 0`.
  - A beat asserts `r_push` and increments `beat_idx`.
  - The last beat asserts `ar_pop` -> IDLE, `last_dir = READ`.
- Grants:
  - `w_grant = (WRITE | WRESP)`; `r_grant = READ`.
  - Grants are never both high.
- Burst length rules:
  - `len_q = 0` is a single-beat burst.
  - `len_q = 2^LEN_W - 1` gives `2^LEN_W` beats; the compare happens before increment, so `beat_idx` never wraps inside a burst.
- Stalls:
  - `w_empty`, `r_full` or `b_full` hold the state and `beat_idx` unchanged.
  - Requests are ignored outside IDLE.

## Timing
- Reset values:
  - State IDLE, `beat_idx = 0`, `len_q = 0`, `last_dir = READ` (so write wins the first tie).
  - All outputs 0.
- Reset asserted mid-burst aborts the burst at the next edge. No pop or push is issued in the reset cycle.
- State, `len_q`, `beat_idx` and `last_dir` are registered.
- `mem_req`, `mem_we`, pops and pushes are combinational from state and FIFO flags; `mem_gnt` feeds pops and pushes only.
- Arbitration latency: a request seen in IDLE at edge N puts the grant high in cycle N+1. The first beat is possible in cycle N+1.
- Minimum cycles per burst:
  - Write: `len + 2` (beats plus WRESP).
  - Read: `len + 1`.
  - IDLE costs 1 cycle between bursts.
- Back-to-back bursts with both requests held alternate W, R, W, R…

## Structure
- Shared package `axi_arb_pkg`: `arb_state_e` (IDLE, WRITE, WRESP, READ) and `dir_e` (DIR_W, DIR_R).
- Natural sub-module: `burst_beat_counter` (load/clear, increment on beat, `last` flag when `cnt == len_q`). It is instantiated once and shared by both directions.

## Test plan
- Write only, `aw_len = 3`, `mem_gnt` always 1 -> `w_pop` high 4 consecutive cycles; `beat_idx` 0,1,2,3; `aw_pop` with the 4th beat; `b_push` the next cycle; IDLE after 6 cycles total.
- Both requests high from reset, both lengths 0 -> grant order W, R, W, R; never simultaneous grants.
- Write burst `len = 2` with `w_empty` high for 3 cycles after beat 0 -> `beat_idx` holds at 1 and no `w_pop` during the stall; completes afterwards. Then `b_full` high for 2 cycles -> stays in WRESP, `b_push` once when released.
- Read `ar_len = 255`, `r_full` toggling -> exactly 256 `r_push`; `ar_pop` only on the last beat; `beat_idx` ends at 255 with no wrap.
- `rst` asserted at beat 2 of a 4-beat write -> next cycle IDLE, all outputs 0, `last_dir = READ`; a following tie grants write.
